// File: rtl/lru_trace_encoder.sv
// Purpose: formats one LRU access result per handshake as an ASCII line and sends it on a UART 8N1 pin.
// Latency: the first start bit leaves 2 clk after accept; each char takes 10 bit times plus a 1-cycle gap.
// Backpressure: res_ready is high only in IDLE, so a held res_valid waits until the whole line has gone out.
// Optional build macro: LRU_EVICT_FIELD_EN adds " E<evict tag>" to miss lines that evicted a line.
module lru_trace_encoder #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic        res_hit,
  input  logic        res_load_store,
  input  logic [16:0] res_tag,
  input  logic [10:0] res_index,
  input  logic        res_evict,
  input  logic [16:0] res_evict_tag,
  output logic        uart_tx,
  output logic        busy,
  output logic [15:0] lines_sent
);

  // CLKS_PER_BIT must be at least 4; the timer is sized to hold 0..CLKS_PER_BIT-1.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

  localparam logic [7:0] CH_H  = 8'h48;
  localparam logic [7:0] CH_M  = 8'h4D;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
`ifdef LRU_EVICT_FIELD_EN
  localparam logic [7:0] CH_E  = 8'h45;
`endif

  // Result captured at accept; the res_* inputs are ignored after that.
  typedef struct packed {
    logic        hit;
    logic        store;
    logic [16:0] tag;
    logic [10:0] index;
`ifdef LRU_EVICT_FIELD_EN
    logic        evict;
    logic [16:0] evict_tag;
`endif
  } res_meta_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state_q, state_d;
  res_meta_t   meta_q;
  logic [TW-1:0] timer_q;
  logic [2:0]  bit_idx_q;
  logic [4:0]  char_idx_q;
  logic [7:0]  shreg_q;
  logic        tx_q;
  logic [15:0] lines_sent_q;
  logic [15:0] lines_sent_d;

  logic        accept;
  logic        bit_done;
  logic        last_char;
  logic        line_done;
  logic [4:0]  last_idx;
  logic [7:0]  char_byte;
  logic [19:0] tag_hex;
  logic [11:0] idx_hex;

`ifdef LRU_EVICT_FIELD_EN
  logic        evict_line;
  logic [19:0] evtag_hex;
  assign evict_line = meta_q.evict & ~meta_q.hit;
  assign evtag_hex  = {3'b000, meta_q.evict_tag};
  assign last_idx   = evict_line ? 5'd20 : 5'd13;
`else
  // Evict inputs have no effect on a line without the evict field.
  logic unused_evict;
  assign unused_evict = &{1'b0, res_evict, res_evict_tag};
  assign last_idx     = 5'd13;
`endif

  // Tag and index are zero-extended to whole hex digits.
  assign tag_hex = {3'b000, meta_q.tag};
  assign idx_hex = {1'b0, meta_q.index};

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign bit_done     = (timer_q == TIMER_LAST);
  assign last_char    = (char_idx_q == last_idx);
  assign lines_sent_d = lines_sent_q + 16'd1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    res_ready = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    line_done = 1'b0;
    case (state_q)
      IDLE: begin
        res_ready = 1'b1;
        busy      = 1'b0;
        if (res_valid) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD:  state_d = START;
      START: if (bit_done) state_d = DATA;
      DATA:  if (bit_done && bit_idx_q == 3'd7) state_d = STOP;
      STOP: begin
        if (bit_done) begin
          if (last_char) begin
            line_done = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d   = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Character selection for the current position in the line.
  always_comb begin
    char_byte = CH_SP;
    case (char_idx_q)
      5'd0:  char_byte = meta_q.hit ? CH_H : CH_M;
      5'd1:  char_byte = meta_q.store ? CH_S : CH_L;
      5'd2:  char_byte = CH_SP;
      5'd3:  char_byte = hex_ascii(tag_hex[19:16]);
      5'd4:  char_byte = hex_ascii(tag_hex[15:12]);
      5'd5:  char_byte = hex_ascii(tag_hex[11:8]);
      5'd6:  char_byte = hex_ascii(tag_hex[7:4]);
      5'd7:  char_byte = hex_ascii(tag_hex[3:0]);
      5'd8:  char_byte = CH_SP;
      5'd9:  char_byte = hex_ascii(idx_hex[11:8]);
      5'd10: char_byte = hex_ascii(idx_hex[7:4]);
      5'd11: char_byte = hex_ascii(idx_hex[3:0]);
      default: begin
        if (char_idx_q == last_idx) begin
          char_byte = CH_LF;
        end else if (char_idx_q == last_idx - 5'd1) begin
          char_byte = CH_CR;
        end
`ifdef LRU_EVICT_FIELD_EN
        else begin
          case (char_idx_q)
            5'd13:   char_byte = CH_E;
            5'd14:   char_byte = hex_ascii(evtag_hex[19:16]);
            5'd15:   char_byte = hex_ascii(evtag_hex[15:12]);
            5'd16:   char_byte = hex_ascii(evtag_hex[11:8]);
            5'd17:   char_byte = hex_ascii(evtag_hex[7:4]);
            5'd18:   char_byte = hex_ascii(evtag_hex[3:0]);
            default: char_byte = CH_SP;
          endcase
        end
`endif
      end
    endcase
  end

  // Capture the result on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
    end else if (accept) begin
`ifdef LRU_EVICT_FIELD_EN
      meta_q <= '{hit: res_hit, store: res_load_store, tag: res_tag, index: res_index,
                  evict: res_evict, evict_tag: res_evict_tag};
`else
      meta_q <= '{hit: res_hit, store: res_load_store, tag: res_tag, index: res_index};
`endif
    end
  end

  // Bit timer runs only while a bit is on the wire and restarts at every bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (state_q == START || state_q == DATA || state_q == STOP) begin
      timer_q <= bit_done ? '0 : timer_q + 1'b1;
    end else begin
      timer_q <= '0;
    end
  end

  // Shift register and data-bit counter: load in LOAD, shift LSB first in DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_idx_q <= '0;
    end else if (state_q == LOAD) begin
      shreg_q   <= char_byte;
      bit_idx_q <= '0;
    end else if (state_q == DATA && bit_done) begin
      shreg_q   <= {1'b0, shreg_q[7:1]};
      bit_idx_q <= bit_idx_q + 3'd1;
    end
  end

  // Character index within the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_idx_q <= '0;
    end else if (accept) begin
      char_idx_q <= '0;
    end else if (state_q == STOP && bit_done && !last_char) begin
      char_idx_q <= char_idx_q + 5'd1;
    end
  end

  // Completed-line counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            lines_sent_q <= '0;
    else if (line_done) lines_sent_q <= lines_sent_d;
  end

  // Registered serial output keeps the pin glitch-free; it trails the state by one cycle,
  // which is what puts the first start bit two cycles after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q <= 1'b1;
    end else begin
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shreg_q[0];
        default: tx_q <= 1'b1;
      endcase
    end
  end

  assign uart_tx    = tx_q;
  assign lines_sent = lines_sent_q;

endmodule

// File: tb/tb_lru_trace_encoder.sv
// Directed bench for lru_trace_encoder at 16 clocks per bit.
// Each line is checked cycle by cycle against the expected 8N1 waveform.
// Tasks run in sequence from one initial block and print one summary line.
module tb_lru_trace_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic        res_hit = 1'b0;
  logic        res_load_store = 1'b0;
  logic [16:0] res_tag = '0;
  logic [10:0] res_index = '0;
  logic        res_evict = 1'b0;
  logic [16:0] res_evict_tag = '0;
  logic        res_ready;
  logic        uart_tx;
  logic        busy;
  logic [15:0] lines_sent;

  int n_assert = 0;
  int n_fail   = 0;

  lru_trace_encoder #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_hit        (res_hit),
    .res_load_store (res_load_store),
    .res_tag        (res_tag),
    .res_index      (res_index),
    .res_evict      (res_evict),
    .res_evict_tag  (res_evict_tag),
    .uart_tx        (uart_tx),
    .busy           (busy),
    .lines_sent     (lines_sent)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one result and hold it until the accepting edge; optionally keep res_valid high afterwards.
  task automatic send(input logic hit, input logic ls, input logic [16:0] tag, input logic [10:0] idx,
                      input logic ev, input logic [16:0] evt, input bit hold);
    int w;
    w = 0;
    while (!res_ready && w < 5000) begin
      tick;
      w++;
    end
    n_assert++;
    if (res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_wait: res_ready=%b after %0d cycles, required 1", res_ready, w);
    end
    res_hit = hit; res_load_store = ls; res_tag = tag; res_index = idx;
    res_evict = ev; res_evict_tag = evt;
    res_valid = 1'b1;
    tick;
    if (!hold) res_valid = 1'b0;
  endtask

  // Called right after the accepting edge. Char k starts at accept+2+161*k:
  // 16 cycles start, 8x16 data LSB first, 16 stop, then one idle cycle before the next char.
  task automatic rx_line(input string body);
    int          n;
    int          span;
    logic [7:0]  exp_b;
    logic [7:0]  got_b;
    logic        exp_bit;
    bit          wave_ok;
    bit          last;
    n = body.len() + 2;
    tick;
    n_assert++;
    if (uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_start: uart_tx=%b one cycle after accept, required 1", uart_tx);
    end
    for (int k = 0; k < n; k++) begin
      if (k < n - 2)       exp_b = body[k];
      else if (k == n - 2) exp_b = 8'h0D;
      else                 exp_b = 8'h0A;
      got_b   = 8'h00;
      wave_ok = 1'b1;
      span    = (k == n - 1) ? 160 : 161;
      for (int j = 0; j < span; j++) begin
        tick;
        if (j < 16)       exp_bit = 1'b0;
        else if (j < 144) exp_bit = exp_b[(j - 16) / 16];
        else              exp_bit = 1'b1;
        if (uart_tx !== exp_bit) wave_ok = 1'b0;
        if (j >= 16 && j < 144 && ((j - 16) % 16) == 8) got_b[(j - 16) / 16] = uart_tx;
        last = (k == n - 1) && (j == span - 1);
        if (busy !== !last || res_ready !== last) wave_ok = 1'b0;
      end
      n_assert++;
      if (!wave_ok || got_b !== exp_b) begin
        n_fail++;
        $display("FAIL line_char%0d: got byte %02h (waveform/handshake ok=%0d), required byte %02h with exact 16-cycle bits",
                 k, got_b, wave_ok, exp_b);
      end
    end
  endtask

  task automatic test_reset;
    bit tx_ok, rdy_ok, busy_ok, cnt_ok;
    repeat (3) tick;
    n_assert++;
    if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: uart_tx=%b, required 1", uart_tx); end
    n_assert++;
    if (res_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: res_ready=%b, required 1", res_ready); end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: busy=%b, required 0", busy); end
    n_assert++;
    if (lines_sent !== 16'h0000) begin n_fail++; $display("FAIL rst_count: lines_sent=%h, required 0000", lines_sent); end
    rst = 1'b0;
    tx_ok = 1; rdy_ok = 1; busy_ok = 1; cnt_ok = 1;
    for (int i = 0; i < 1000; i++) begin
      tick;
      if (uart_tx !== 1'b1) tx_ok = 0;
      if (res_ready !== 1'b1) rdy_ok = 0;
      if (busy !== 1'b0) busy_ok = 0;
      if (lines_sent !== 16'h0000) cnt_ok = 0;
    end
    n_assert++;
    if (!tx_ok) begin n_fail++; $display("FAIL idle_tx: uart_tx left 1 while idle, now %b, required 1", uart_tx); end
    n_assert++;
    if (!rdy_ok) begin n_fail++; $display("FAIL idle_ready: res_ready dropped while idle, now %b, required 1", res_ready); end
    n_assert++;
    if (!busy_ok) begin n_fail++; $display("FAIL idle_busy: busy rose while idle, now %b, required 0", busy); end
    n_assert++;
    if (!cnt_ok) begin n_fail++; $display("FAIL idle_count: lines_sent=%h, required 0000", lines_sent); end
  endtask

  task automatic test_reset_mid;
    send(1'b1, 1'b0, 17'h1ABCD, 11'h7FF, 1'b0, 17'h0, 1'b0);
    // accept+830 lies in data bit 0 of char 5 ('B' = 0x42, bit 0 low)
    repeat (830) tick;
    n_assert++;
    if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_data: uart_tx=%b before reset, required 0", uart_tx); end
    rst = 1'b1;
    #1;
    n_assert++;
    if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tx: uart_tx=%b, required 1", uart_tx); end
    n_assert++;
    if (res_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: res_ready=%b, required 1", res_ready); end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: busy=%b, required 0", busy); end
    n_assert++;
    if (lines_sent !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_count: lines_sent=%h, required 0000", lines_sent); end
    repeat (2) tick;
    rst = 1'b0;
    tick;
    send(1'b0, 1'b0, 17'h0BEEF, 11'h4A5, 1'b0, 17'h0, 1'b0);
    rx_line("ML 0BEEF 4A5");
    n_assert++;
    if (lines_sent !== 16'h0001) begin n_fail++; $display("FAIL mid_after_count: lines_sent=%h, required 0001", lines_sent); end
  endtask

  task automatic test_hit_load;
    send(1'b1, 1'b0, 17'h1ABCD, 11'h7FF, 1'b0, 17'h0, 1'b0);
    rx_line("HL 1ABCD 7FF");
    n_assert++;
    if (lines_sent !== 16'h0002) begin n_fail++; $display("FAIL hit_load_count: lines_sent=%h, required 0002", lines_sent); end
  endtask

  task automatic test_back_to_back;
    send(1'b0, 1'b1, 17'h00000, 11'h000, 1'b0, 17'h0, 1'b1);
    // second result appears on the still-valid inputs; it must wait for the line to finish
    res_hit = 1'b1; res_load_store = 1'b1; res_tag = 17'h00F0A; res_index = 11'h123;
    rx_line("MS 00000 000");
    n_assert++;
    if (lines_sent !== 16'h0003) begin n_fail++; $display("FAIL b2b_first_count: lines_sent=%h, required 0003", lines_sent); end
    tick;
    res_valid = 1'b0;
    rx_line("HS 00F0A 123");
    n_assert++;
    if (lines_sent !== 16'h0004) begin n_fail++; $display("FAIL b2b_second_count: lines_sent=%h, required 0004", lines_sent); end
  endtask

  task automatic test_wrap;
    force dut.lines_sent_d = 16'hFFFF;
    send(1'b1, 1'b1, 17'h1FFFF, 11'h000, 1'b0, 17'h0, 1'b0);
    rx_line("HS 1FFFF 000");
    release dut.lines_sent_d;
    n_assert++;
    if (lines_sent !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: lines_sent=%h, required FFFF", lines_sent); end
    send(1'b0, 1'b0, 17'h00A5C, 11'h3C0, 1'b0, 17'h0, 1'b0);
    rx_line("ML 00A5C 3C0");
    n_assert++;
    if (lines_sent !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: lines_sent=%h, required 0000", lines_sent); end
  endtask

  task automatic test_evict;
    send(1'b0, 1'b0, 17'h00123, 11'h001, 1'b1, 17'h00042, 1'b0);
`ifdef LRU_EVICT_FIELD_EN
    rx_line("ML 00123 001 E00042");
`else
    rx_line("ML 00123 001");
`endif
    n_assert++;
    if (lines_sent !== 16'h0001) begin n_fail++; $display("FAIL evict_miss_count: lines_sent=%h, required 0001", lines_sent); end
    send(1'b1, 1'b0, 17'h00123, 11'h001, 1'b1, 17'h00042, 1'b0);
    rx_line("HL 00123 001");
    n_assert++;
    if (lines_sent !== 16'h0002) begin n_fail++; $display("FAIL evict_hit_count: lines_sent=%h, required 0002", lines_sent); end
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_hit_load;
    test_back_to_back;
    test_wrap;
    test_evict;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
